// File: rtl/out_tile_writer.sv
// -----------------------------------------------------------------------------
// out_tile_writer
//
// Accumulates groups of partial output tiles and writes the finished tile to
// memory one element at a time.
//
// There are two accumulator banks, so one group can build up while the other
// group drains. Each bank holds 6x6 16-bit signed accumulators and a tag: the
// output channel, the row/column origin, the tile size, the tiles summed so
// far and the group length.
//
// A bank is FREE, ACCUM or FULL:
//   - The first tile of a group claims a FREE bank. Bank 0 is tried first.
//   - Later tiles add into the ACCUM bank. Their tag inputs are ignored.
//   - When the group length is reached the bank becomes FULL.
//   - A tile that finds no ACCUM bank and no FREE bank is dropped, and the
//     sticky overflow flag is raised.
//
// The drain FSM (IDLE -> WRITE -> DONE) takes the oldest FULL bank. It walks
// the bank row-major over N x N elements, where N is 6 or 4. Elements outside
// the H x W output plane use one cycle each with no write.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   tile_i              6x6 array of signed 12-bit partial results
//   tile_valid_i        tile and tag inputs valid this cycle (no backpressure)
//   tile_od_i           output channel of the tile
//   tile_x_i, tile_y_i  row and column of element [0][0]
//   tile_size_type_i    0 = 6x6 tile, 1 = 4x4 tile
//   cfg_id_count_i      partial tiles per group, sampled by the first tile
//   cfg_height_i        output plane height H
//   cfg_width_i         output plane width W
//   mem_wr_en_o         write request
//   mem_addr_o          element address
//   mem_wdata_o         saturated 12-bit element value
//   mem_ready_i         memory accepts the write when wr_en and ready are high
//   busy_o              a bank is in use or the drain is active
//   group_done_o        one-cycle pulse after the last write of a group
//   overflow_o          sticky, set when a tile has been dropped
// -----------------------------------------------------------------------------
module out_tile_writer #(
  parameter int ID_MAX = 16,
  parameter int ADDR_W = 25
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [11:0]       tile_i [0:5][0:5],
  input  logic                     tile_valid_i,
  input  logic [7:0]               tile_od_i,
  input  logic [8:0]               tile_x_i,
  input  logic [8:0]               tile_y_i,
  input  logic                     tile_size_type_i,
  input  logic [4:0]               cfg_id_count_i,
  input  logic [8:0]               cfg_height_i,
  input  logic [8:0]               cfg_width_i,
  output logic                     mem_wr_en_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic signed [11:0]       mem_wdata_o,
  input  logic                     mem_ready_i,
  output logic                     busy_o,
  output logic                     group_done_o,
  output logic                     overflow_o
);

  typedef enum logic [1:0] {
    BANK_FREE,
    BANK_ACCUM,
    BANK_FULL
  } bank_state_t;

  typedef enum logic [1:0] {
    DRAIN_IDLE,
    DRAIN_WRITE,
    DRAIN_DONE
  } drain_state_t;

  // Bank storage
  bank_state_t        bank_state [2];
  logic signed [15:0] acc        [2][0:5][0:5];
  logic [7:0]         tag_od     [2];
  logic [8:0]         tag_x      [2];
  logic [8:0]         tag_y      [2];
  logic               tag_size   [2];
  logic [4:0]         tag_count  [2];
  logic [4:0]         tag_target [2];
  logic               older_full;

  // Drain state
  drain_state_t drain_state;
  logic         drain_bank;
  logic [2:0]   cur_i;
  logic [2:0]   cur_j;

  // Tile-side decode
  logic       accum_hit;
  logic       accum_bank;
  logic       claim_ok;
  logic       claim_bank;
  logic [4:0] id_target;

  // Drain-side decode
  logic               any_full;
  logic               pick_bank;
  logic               sel_bank;
  logic [2:0]         n_max;
  logic [2:0]         nxt_i;
  logic [2:0]         nxt_j;
  logic               last_elem;
  logic [9:0]         row;
  logic [9:0]         col;
  logic               in_range;
  logic [ADDR_W-1:0]  addr_calc;
  logic signed [15:0] acc_val;
  logic signed [11:0] wdata_calc;

  function automatic logic signed [15:0] sext12(input logic signed [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

  // Group length clamped into 1..ID_MAX. This keeps the 16-bit accumulators
  // from wrapping even when the configuration is out of range.
  always_comb begin
    id_target = cfg_id_count_i;
    if (cfg_id_count_i == 5'd0) begin
      id_target = 5'd1;
    end else if (32'(cfg_id_count_i) > ID_MAX) begin
      id_target = 5'(ID_MAX);
    end
  end

  // Pick the bank for an incoming tile. At most one bank is ever in ACCUM,
  // because a new group starts only when there is no ACCUM bank.
  always_comb begin
    accum_hit  = (bank_state[0] == BANK_ACCUM) || (bank_state[1] == BANK_ACCUM);
    accum_bank = (bank_state[1] == BANK_ACCUM);
    claim_ok   = (bank_state[0] == BANK_FREE) || (bank_state[1] == BANK_FREE);
    claim_bank = (bank_state[0] != BANK_FREE);
  end

  // Bank accumulation and claim.
  // A bank being drained stays FULL through the DONE cycle. So a tile that
  // arrives in the DONE cycle cannot see that bank as free until the next
  // edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        bank_state[b] <= BANK_FREE;
        tag_od[b]     <= '0;
        tag_x[b]      <= '0;
        tag_y[b]      <= '0;
        tag_size[b]   <= 1'b0;
        tag_count[b]  <= '0;
        tag_target[b] <= '0;
        for (int i = 0; i < 6; i++) begin
          for (int j = 0; j < 6; j++) begin
            acc[b][i][j] <= '0;
          end
        end
      end
      older_full <= 1'b0;
    end else begin
      if (drain_state == DRAIN_DONE) begin
        bank_state[drain_bank] <= BANK_FREE;
      end
      if (tile_valid_i) begin
        if (accum_hit) begin
          for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
              acc[accum_bank][i][j] <= acc[accum_bank][i][j] + sext12(tile_i[i][j]);
            end
          end
          tag_count[accum_bank] <= tag_count[accum_bank] + 5'd1;
          if ((tag_count[accum_bank] + 5'd1) == tag_target[accum_bank]) begin
            bank_state[accum_bank] <= BANK_FULL;
            if (bank_state[~accum_bank] != BANK_FULL) begin
              older_full <= accum_bank;
            end
          end
        end else if (claim_ok) begin
          for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
              acc[claim_bank][i][j] <= sext12(tile_i[i][j]);
            end
          end
          tag_od[claim_bank]     <= tile_od_i;
          tag_x[claim_bank]      <= tile_x_i;
          tag_y[claim_bank]      <= tile_y_i;
          tag_size[claim_bank]   <= tile_size_type_i;
          tag_count[claim_bank]  <= 5'd1;
          tag_target[claim_bank] <= id_target;
          if (id_target == 5'd1) begin
            bank_state[claim_bank] <= BANK_FULL;
            if (bank_state[~claim_bank] != BANK_FULL) begin
              older_full <= claim_bank;
            end
          end else begin
            bank_state[claim_bank] <= BANK_ACCUM;
          end
        end
      end
    end
  end

  // A dropped tile stays flagged until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_o <= 1'b0;
    end else if (tile_valid_i && !accum_hit && !claim_ok) begin
      overflow_o <= 1'b1;
    end
  end

  // Work out the element that goes on the memory port at the next edge.
  // In IDLE this is element (0,0) of the bank about to start draining.
  // In WRITE it is the element after the one now on the port.
  always_comb begin
    any_full  = (bank_state[0] == BANK_FULL) || (bank_state[1] == BANK_FULL);
    if ((bank_state[0] == BANK_FULL) && (bank_state[1] == BANK_FULL)) begin
      pick_bank = older_full;
    end else begin
      pick_bank = (bank_state[1] == BANK_FULL);
    end
    sel_bank  = (drain_state == DRAIN_IDLE) ? pick_bank : drain_bank;
    n_max     = tag_size[sel_bank] ? 3'd3 : 3'd5;
    last_elem = (cur_i == n_max) && (cur_j == n_max);

    nxt_i = 3'd0;
    nxt_j = 3'd0;
    if (drain_state != DRAIN_IDLE) begin
      if (cur_j == n_max) begin
        nxt_i = cur_i + 3'd1;
        nxt_j = 3'd0;
      end else begin
        nxt_i = cur_i;
        nxt_j = cur_j + 3'd1;
      end
    end

    row      = {1'b0, tag_x[sel_bank]} + {7'd0, nxt_i};
    col      = {1'b0, tag_y[sel_bank]} + {7'd0, nxt_j};
    in_range = (row < {1'b0, cfg_height_i}) && (col < {1'b0, cfg_width_i});

    // ADDR_W-bit modular arithmetic gives the same result as truncating the
    // full-width address.
    addr_calc = (ADDR_W'(tag_od[sel_bank]) * ADDR_W'(cfg_height_i) + ADDR_W'(row))
                * ADDR_W'(cfg_width_i) + ADDR_W'(col);

    acc_val = acc[sel_bank][nxt_i][nxt_j];
    if (acc_val > 16'sd2047) begin
      wdata_calc = 12'sh7FF;
    end else if (acc_val < -16'sd2048) begin
      wdata_calc = 12'sh800;
    end else begin
      wdata_calc = acc_val[11:0];
    end
  end

  // Drain FSM with registered memory outputs.
  // An element that is being written holds the port until memory accepts it.
  // A skipped element uses exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_state  <= DRAIN_IDLE;
      drain_bank   <= 1'b0;
      cur_i        <= '0;
      cur_j        <= '0;
      mem_wr_en_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      group_done_o <= 1'b0;
    end else begin
      case (drain_state)
        DRAIN_IDLE: begin
          group_done_o <= 1'b0;
          if (any_full) begin
            drain_bank  <= pick_bank;
            cur_i       <= nxt_i;
            cur_j       <= nxt_j;
            mem_wr_en_o <= in_range;
            mem_addr_o  <= addr_calc;
            mem_wdata_o <= wdata_calc;
            drain_state <= DRAIN_WRITE;
          end
        end
        DRAIN_WRITE: begin
          if (mem_wr_en_o && !mem_ready_i) begin
            drain_state <= DRAIN_WRITE;
          end else if (last_elem) begin
            mem_wr_en_o  <= 1'b0;
            group_done_o <= 1'b1;
            drain_state  <= DRAIN_DONE;
          end else begin
            cur_i       <= nxt_i;
            cur_j       <= nxt_j;
            mem_wr_en_o <= in_range;
            mem_addr_o  <= addr_calc;
            mem_wdata_o <= wdata_calc;
          end
        end
        DRAIN_DONE: begin
          group_done_o <= 1'b0;
          drain_state  <= DRAIN_IDLE;
        end
        default: begin
          drain_state <= DRAIN_IDLE;
        end
      endcase
    end
  end

  assign busy_o = (bank_state[0] != BANK_FREE) || (bank_state[1] != BANK_FREE)
                  || (drain_state != DRAIN_IDLE);

endmodule

// File: tb/tb_out_tile_writer.sv
// -----------------------------------------------------------------------------
// tb_out_tile_writer
//
// Directed testbench for out_tile_writer. Writes accepted by memory are logged
// with the cycle they happened in. They are then checked against addresses and
// data worked out by hand from the tile tags and the plane size.
// -----------------------------------------------------------------------------
module tb_out_tile_writer;

  logic               clk;
  logic               reset;
  logic signed [11:0] tile [0:5][0:5];
  logic               tile_valid;
  logic [7:0]         tile_od;
  logic [8:0]         tile_x;
  logic [8:0]         tile_y;
  logic               tile_size_type;
  logic [4:0]         cfg_id_count;
  logic [8:0]         cfg_height;
  logic [8:0]         cfg_width;
  logic               mem_wr_en;
  logic [24:0]        mem_addr;
  logic signed [11:0] mem_wdata;
  logic               mem_ready;
  logic               busy;
  logic               group_done;
  logic               overflow;

  int tests_run;
  int tests_failed;
  int cyc;
  int done_cnt;
  int done_cyc;
  int wr_addr [$];
  int wr_data [$];
  int wr_cyc  [$];

  out_tile_writer #(.ID_MAX(16), .ADDR_W(25)) dut (
    .clk              (clk),
    .reset            (reset),
    .tile_i           (tile),
    .tile_valid_i     (tile_valid),
    .tile_od_i        (tile_od),
    .tile_x_i         (tile_x),
    .tile_y_i         (tile_y),
    .tile_size_type_i (tile_size_type),
    .cfg_id_count_i   (cfg_id_count),
    .cfg_height_i     (cfg_height),
    .cfg_width_i      (cfg_width),
    .mem_wr_en_o      (mem_wr_en),
    .mem_addr_o       (mem_addr),
    .mem_wdata_o      (mem_wdata),
    .mem_ready_i      (mem_ready),
    .busy_o           (busy),
    .group_done_o     (group_done),
    .overflow_o       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge. If the memory port will accept a write at the
  // next rising edge, log it. Then step to the next falling edge.
  task automatic cycle();
    if (mem_wr_en && mem_ready) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(int'(mem_wdata));
      wr_cyc.push_back(cyc);
    end
    if (group_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cnt = 0;
    done_cyc = 0;
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        tile[i][j] = 12'(v);
  endtask

  // Present the current tile contents with the given tag for one cycle
  task automatic applyStimulus(input int od, input int x, input int y, input int size);
    tile_od        = 8'(od);
    tile_x         = 9'(x);
    tile_y         = 9'(y);
    tile_size_type = 1'(size);
    tile_valid     = 1'b1;
    cycle();
    tile_valid     = 1'b0;
  endtask

  task automatic wait_groups(input string tag, input int target, input int limit);
    for (int k = 0; k < limit; k++) begin
      if (done_cnt >= target) break;
      cycle();
    end
    checkOutput({tag, "_groups_done"}, done_cnt, target);
  endtask

  // Check a 4x4 group written at origin (0,0) on an 8x8 plane
  task automatic check_4x4_plane8(input string tag, input int first, input int od, input int value);
    for (int k = 0; k < 16; k++) begin
      if (first + k < wr_addr.size()) begin
        checkOutput($sformatf("%s_addr%0d", tag, k), wr_addr[first + k], od * 64 + (k / 4) * 8 + (k % 4));
        checkOutput($sformatf("%s_data%0d", tag, k), wr_data[first + k], value);
      end
    end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    cyc            = 0;
    done_cnt       = 0;
    done_cyc       = 0;
    reset          = 1'b1;
    tile_valid     = 1'b0;
    tile_od        = '0;
    tile_x         = '0;
    tile_y         = '0;
    tile_size_type = 1'b0;
    cfg_id_count   = 5'd1;
    cfg_height     = 9'd8;
    cfg_width      = 9'd8;
    mem_ready      = 1'b1;
    fill_const(0);

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_wr_en", int'(mem_wr_en), 0);
    checkOutput("rst_addr", int'(mem_addr), 0);
    checkOutput("rst_wdata", int'(mem_wdata), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_group_done", int'(group_done), 0);
    checkOutput("rst_overflow", int'(overflow), 0);
    reset = 1'b0;
    cycle();

    // Single 4x4 tile of 5s on an 8x8 plane
    clear_log();
    cfg_id_count = 5'd1;
    fill_const(5);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t036_busy_after_claim", int'(busy), 1);
    wait_groups("t036", 1, 100);
    checkOutput("t036_nwr", wr_addr.size(), 16);
    check_4x4_plane8("t036", 0, 0, 5);
    checkOutput("t036_idle_busy", int'(busy), 0);

    // Three 6x6 tiles of +1000 saturate high, then three of -1000 saturate low
    cfg_id_count = 5'd3;
    cfg_height   = 9'd6;
    cfg_width    = 9'd6;
    for (int pass = 0; pass < 2; pass++) begin
      clear_log();
      fill_const(pass == 0 ? 1000 : -1000);
      repeat (3) applyStimulus(0, 0, 0, 0);
      wait_groups($sformatf("t037_%0d", pass), 1, 100);
      checkOutput($sformatf("t037_%0d_nwr", pass), wr_addr.size(), 36);
      for (int k = 0; k < 36; k++) begin
        if (k < wr_addr.size()) begin
          checkOutput($sformatf("t037_%0d_addr%0d", pass, k), wr_addr[k], k);
          checkOutput($sformatf("t037_%0d_data%0d", pass, k), wr_data[k], pass == 0 ? 2047 : -2048);
        end
      end
    end

    // Two-tile group with varying data, nonzero od/x/y and the second tile's tag ignored
    clear_log();
    cfg_id_count = 5'd2;
    cfg_height   = 9'd5;
    cfg_width    = 9'd7;
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        tile[i][j] = 12'(100 * i + 10 * j - 200);
    applyStimulus(3, 1, 2, 1);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        tile[i][j] = 12'(j - 3 * i);
    applyStimulus(9, 0, 0, 0);
    wait_groups("tsum", 1, 100);
    checkOutput("tsum_nwr", wr_addr.size(), 16);
    for (int k = 0; k < 16; k++) begin
      if (k < wr_addr.size()) begin
        checkOutput($sformatf("tsum_addr%0d", k), wr_addr[k], 114 + 7 * (k / 4) + (k % 4));
        checkOutput($sformatf("tsum_data%0d", k), wr_data[k], 97 * (k / 4) + 11 * (k % 4) - 200);
      end
    end

    // Tile hanging off the corner of a 6x6 plane: four writes, 32 skipped cycles
    clear_log();
    cfg_id_count = 5'd1;
    cfg_height   = 9'd6;
    cfg_width    = 9'd6;
    fill_const(9);
    applyStimulus(0, 4, 4, 0);
    wait_groups("t038", 1, 100);
    checkOutput("t038_nwr", wr_addr.size(), 4);
    if (wr_addr.size() == 4) begin
      checkOutput("t038_addr0", wr_addr[0], 28);
      checkOutput("t038_addr1", wr_addr[1], 29);
      checkOutput("t038_addr2", wr_addr[2], 34);
      checkOutput("t038_addr3", wr_addr[3], 35);
      checkOutput("t038_data3", wr_data[3], 9);
      checkOutput("t038_gap_row", wr_cyc[2] - wr_cyc[0], 6);
      checkOutput("t038_done_offset", done_cyc - wr_cyc[0], 36);
    end

    // Memory stalls for three cycles on the first write
    clear_log();
    cfg_height = 9'd8;
    cfg_width  = 9'd8;
    fill_const(7);
    mem_ready  = 1'b0;
    applyStimulus(0, 0, 0, 1);
    for (int k = 0; k < 10; k++) begin
      if (mem_wr_en) break;
      cycle();
    end
    for (int s = 0; s < 3; s++) begin
      checkOutput($sformatf("t039_stall%0d_wr_en", s), int'(mem_wr_en), 1);
      checkOutput($sformatf("t039_stall%0d_addr", s), int'(mem_addr), 0);
      checkOutput($sformatf("t039_stall%0d_data", s), int'(mem_wdata), 7);
      cycle();
    end
    mem_ready = 1'b1;
    wait_groups("t039", 1, 100);
    checkOutput("t039_nwr", wr_addr.size(), 16);
    check_4x4_plane8("t039", 0, 0, 7);

    // Three back-to-back single-tile groups while memory is blocked
    clear_log();
    mem_ready = 1'b0;
    fill_const(1);
    applyStimulus(0, 0, 0, 1);
    fill_const(2);
    applyStimulus(1, 0, 0, 1);
    checkOutput("t040_no_overflow_yet", int'(overflow), 0);
    fill_const(3);
    applyStimulus(2, 0, 0, 1);
    checkOutput("t040_overflow_set", int'(overflow), 1);
    repeat (4) cycle();
    checkOutput("t040_overflow_held", int'(overflow), 1);
    checkOutput("t040_busy", int'(busy), 1);
    mem_ready = 1'b1;
    wait_groups("t040", 2, 200);
    checkOutput("t040_nwr", wr_addr.size(), 32);
    check_4x4_plane8("t040_g0", 0, 0, 1);
    check_4x4_plane8("t040_g1", 16, 1, 2);
    repeat (3) cycle();
    checkOutput("t040_overflow_sticky", int'(overflow), 1);
    reset = 1'b1;
    cycle();
    checkOutput("t040_overflow_cleared", int'(overflow), 0);
    reset = 1'b0;
    cycle();

    // Reset in the middle of a drain
    clear_log();
    cfg_height = 9'd6;
    cfg_width  = 9'd6;
    fill_const(4);
    applyStimulus(0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      if (wr_addr.size() >= 5) break;
      cycle();
    end
    checkOutput("t041_mid_write", int'(mem_wr_en), 1);
    reset = 1'b1;
    #1;
    checkOutput("t041_wr_en", int'(mem_wr_en), 0);
    checkOutput("t041_addr", int'(mem_addr), 0);
    checkOutput("t041_wdata", int'(mem_wdata), 0);
    checkOutput("t041_busy", int'(busy), 0);
    checkOutput("t041_group_done", int'(group_done), 0);
    checkOutput("t041_overflow", int'(overflow), 0);
    cycle();
    reset = 1'b0;
    clear_log();
    repeat (60) cycle();
    checkOutput("t041_no_writes", wr_addr.size(), 0);
    checkOutput("t041_no_done", done_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
